dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256; number of 32-bit words of backing storage, power of two.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2; extra wait states between request accept and response, range 0..15.
REQ-003 SHALL have port clk, input, 1 bit; single clock, all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit; asynchronous, active-low reset; the port name is reset, and it is asserted when low.
REQ-005 SHALL have port req_valid, input, 1 bit; initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit; responder can accept a request.
REQ-007 SHALL have port req_write, input, 1 bit; 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32 bits; byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits; store data.
REQ-010 SHALL have port req_wstrb, input, 4 bits; byte enables for stores, bit i covers wdata[8i+7:8i].
REQ-011 SHALL have port resp_valid, output, 1 bit; response is present.
REQ-012 SHALL have port resp_ready, input, 1 bit; initiator accepts the response.
REQ-013 SHALL have port resp_rdata, output, 32 bits; load data, 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1 bit; access was misaligned or out of range.
REQ-015 SHALL have port busy, output, 1 bit; high whenever the FSM is not IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT, and RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; a request is accepted on the edge where req_valid && req_ready.
REQ-018 SHALL latch req_write, req_addr, req_wdata, and req_wstrb on accept; later changes on the request inputs SHALL have no effect.
REQ-019 On accept, SHALL go to WAIT and load the wait counter with WAIT_CYCLES when WAIT_CYCLES>0; otherwise SHALL go directly to RESP.
REQ-020 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where the counter reaches 0.
REQ-021 On entry to RESP, SHALL register resp_valid=1 together with resp_rdata and resp_err; latency SHALL be 1+WAIT_CYCLES edges from accept to resp_valid high.
REQ-022 SHALL flag an error when addr[1:0]!=0, or when addr[31:2] >= DEPTH_WORDS (no wrap-around of the word index).
REQ-023 On an error, SHALL perform no memory write, set resp_err=1, and drive resp_rdata=0.
REQ-024 For a valid store, SHALL commit to memory on the RESP-entry edge, updating only the strobed bytes; wstrb=0 SHALL write nothing but still respond with err=0.
REQ-025 For a valid load, resp_rdata SHALL equal the memory word at the RESP-entry edge, including a store committed in an earlier transaction.
REQ-026 SHALL hold resp_valid, resp_rdata, and resp_err stable in RESP until resp_ready=1, and return to IDLE on that edge.
REQ-027 SHALL clear resp_valid, resp_rdata, and resp_err to 0 on leaving RESP.
REQ-028 SHALL accept no new request in the same cycle as the response handshake; the minimum spacing between accepts is WAIT_CYCLES+2 cycles.
REQ-029 SHALL ignore resp_ready outside RESP.
REQ-030 SHALL NOT reset the memory array; its contents are undefined until written.

Reset
REQ-031 While reset is low, SHALL force state=IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, and counter=0.
REQ-032 SHALL drive req_ready=1 from the first rising edge after reset deasserts.
REQ-033 SHALL abort a transaction interrupted by reset: no response; a store whose RESP-entry edge has not occurred SHALL NOT be written.

Verification
REQ-034 Store addr=0x10, wdata=0xDEADBEEF, wstrb=0xF, then load 0x10 -> resp_rdata=0xDEADBEEF, err=0; resp_valid rises 3 edges after each accept (WAIT_CYCLES=2).
REQ-035 Store 0x10 with wdata=0x11223344, wstrb=0x5, over 0xDEADBEEF, then load -> resp_rdata=0xDE22BE44.
REQ-036 Load addr=0x12 -> err=1, rdata=0; load addr=0x400 (DEPTH_WORDS=256) -> err=1; a store to 0x400 SHALL NOT alter word 0.
REQ-037 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata, and err stable, req_ready=0; resp_ready=1 -> IDLE next edge, req_ready=1.
REQ-038 Assert reset low during WAIT of a store to 0x20 over known 0xCAFEF00D -> outputs zeroed immediately; after release, load 0x20 -> 0xCAFEF00D.
REQ-039 With WAIT_CYCLES=0, back-to-back requests with req_valid held high -> accepts every 2 cycles, resp_valid one edge after each accept.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with
// fixed wait states, byte-strobed stores and range/alignment errors.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        rdy_q;

    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic          eff_write;
    logic [31:0]   eff_addr;
    logic [31:0]   eff_wdata;
    logic [3:0]    eff_wstrb;
    logic          eff_err;
    logic [AW-1:0] eff_idx;

    assign req_ready = rdy_q;
    assign busy      = (state_q != IDLE);
    assign accept    = req_valid && rdy_q;

    // Next state and wait counter; RESP is entered as the counter hits 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Zero-wait requests resolve on the accept edge, so use live inputs then
    always_comb begin
        eff_write  = (state_q == IDLE) ? req_write : wr_q;
        eff_addr   = (state_q == IDLE) ? req_addr  : addr_q;
        eff_wdata  = (state_q == IDLE) ? req_wdata : wdata_q;
        eff_wstrb  = (state_q == IDLE) ? req_wstrb : wstrb_q;
        eff_err    = (eff_addr[1:0] != 2'b00) ||
                     ({2'b00, eff_addr[31:2]} >= 32'(DEPTH_WORDS));
        eff_idx    = eff_addr[AW+1:2];
        enter_resp = (state_q != RESP) && (state_d == RESP);
    end

    // State, counter and ready registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= (state_d == IDLE);
        end
    end

    // Capture the request on accept so later input changes are ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
        end else if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

    // Response registers: set on RESP entry, cleared on the handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else if (enter_resp) begin
            resp_valid <= 1'b1;
            resp_err   <= eff_err;
            resp_rdata <= (eff_err || eff_write) ? 32'd0 : mem[eff_idx];
        end else if (state_q == RESP && resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end
    end

    // Storage commit on RESP entry, strobed bytes only, never on error
    always_ff @(posedge clk) begin
        if (enter_resp && eff_write && !eff_err) begin
            for (int b = 0; b < 4; b++) begin
                if (eff_wstrb[b]) begin
                    mem[eff_idx][8*b +: 8] <= eff_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder with
// WAIT_CYCLES=2 (dut a) and WAIT_CYCLES=0 (dut b).
module tb_dmem_responder;

    logic clk = 1'b0;
    logic reset;

    logic        a_req_valid, a_req_ready, a_req_write;
    logic [31:0] a_req_addr, a_req_wdata;
    logic [3:0]  a_req_wstrb;
    logic        a_resp_valid, a_resp_ready, a_resp_err, a_busy;
    logic [31:0] a_resp_rdata;

    logic        b_req_valid, b_req_ready, b_req_write;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [3:0]  b_req_wstrb;
    logic        b_resp_valid, b_resp_ready, b_resp_err, b_busy;
    logic [31:0] b_resp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_write(a_req_write), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .busy(a_busy)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .busy(b_busy)
    );

    // Drives one transaction on dut a; lat counts edges from accept
    // (inclusive) to resp_valid seen high; 99 means no accept.
    task automatic do_req(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output logic e,
                          output int lat);
        int n;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_write = w; a_req_addr = a;
        a_req_wdata = d; a_req_wstrb = s;
        n = 0;
        while (!a_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        a_req_valid = 1'b0; a_req_write = ~w; a_req_addr = 32'hFFFF_FFF3;
        a_req_wdata = ~d; a_req_wstrb = 4'hF;
        lat = 1;
        while (!a_resp_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        rd = a_resp_rdata;
        e  = a_resp_err;
        if (n >= 20) lat = 99;
        a_resp_ready = 1'b1;
        @(negedge clk);
        a_resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        a_req_valid = 0; a_req_write = 0; a_req_addr = 0;
        a_req_wdata = 0; a_req_wstrb = 0; a_resp_ready = 0;
        b_req_valid = 0; b_req_write = 0; b_req_addr = 0;
        b_req_wdata = 0; b_req_wstrb = 0; b_resp_ready = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_req_ready, a_resp_valid, a_resp_err, a_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl: got %b exp 0000",
                     {a_req_ready, a_resp_valid, a_resp_err, a_busy});
        end
        checks++;
        if (a_resp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata: got %h exp 00000000", a_resp_rdata);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (a_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b exp 0", a_req_ready);
        end
        @(negedge clk);
        checks++;
        if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: got %b%b exp 11",
                     a_req_ready, b_req_ready);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic e; int lat;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
        checks++;
        if ({e, rd} !== 33'd0 || lat != 3) begin
            errors++;
            $display("FAIL store_10: err=%b rd=%h lat=%0d exp 0 0 3", e, rd, lat);
        end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0 || lat != 3) begin
            errors++;
            $display("FAIL load_10: rd=%h err=%b lat=%0d exp deadbeef 0 3",
                     rd, e, lat);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic e; int lat;
        do_req(1'b1, 32'h10, 32'h11223344, 4'h5, rd, e, lat);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hDE22BE44 || e !== 1'b0) begin
            errors++;
            $display("FAIL strobe_5: rd=%h err=%b exp de22be44 0", rd, e);
        end
        do_req(1'b1, 32'h10, 32'h99999999, 4'h0, rd, e, lat);
        checks++;
        if (e !== 1'b0 || lat != 3) begin
            errors++;
            $display("FAIL strobe_0_resp: err=%b lat=%0d exp 0 3", e, lat);
        end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL strobe_0_data: rd=%h exp de22be44", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int lat;
        do_req(1'b1, 32'h0, 32'h01234567, 4'hF, rd, e, lat);
        do_req(1'b0, 32'h12, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'd0 || lat != 3) begin
            errors++;
            $display("FAIL misaligned: err=%b rd=%h lat=%0d exp 1 0 3", e, rd, lat);
        end
        do_req(1'b0, 32'h400, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL range_load: err=%b rd=%h exp 1 0", e, rd);
        end
        do_req(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL range_store: err=%b rd=%h exp 1 0", e, rd);
        end
        do_req(1'b1, 32'h8000_0010, 32'hFFFFFFFF, 4'hF, rd, e, lat);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL high_addr: err=%b exp 1", e);
        end
        do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h01234567 || e !== 1'b0) begin
            errors++;
            $display("FAIL word0_kept: rd=%h err=%b exp 01234567 0", rd, e);
        end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL word4_kept: rd=%h exp de22be44", rd);
        end
        do_req(1'b1, 32'h3FC, 32'h5A5A0001, 4'hF, rd, e, lat);
        do_req(1'b0, 32'h3FC, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h5A5A0001 || e !== 1'b0) begin
            errors++;
            $display("FAIL last_word: rd=%h err=%b exp 5a5a0001 0", rd, e);
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h10;
        n = 0;
        while (!a_req_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        a_req_valid = 1'b0;
        n = 0;
        while (!a_resp_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (a_resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_resp_timeout: valid=%b exp 1", a_resp_valid);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'hDE22BE44 ||
                a_resp_err !== 1'b0 || a_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: v=%b rd=%h e=%b rr=%b exp 1 de22be44 0 0",
                         i, a_resp_valid, a_resp_rdata, a_resp_err, a_req_ready);
            end
        end
        a_resp_ready = 1'b1;
        @(negedge clk);
        a_resp_ready = 1'b0;
        checks++;
        if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1 ||
            a_busy !== 1'b0 || a_resp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL bp_release: v=%b rr=%b busy=%b rd=%h exp 0 1 0 0",
                     a_resp_valid, a_req_ready, a_busy, a_resp_rdata);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic e; int lat; int n;
        do_req(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, e, lat);
        @(negedge clk);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h20;
        a_req_wdata = 32'h0BADBEEF; a_req_wstrb = 4'hF;
        n = 0;
        while (!a_req_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        a_req_valid = 1'b0;
        checks++;
        if (a_busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_wait: busy=%b exp 1", a_busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({a_req_ready, a_resp_valid, a_resp_err, a_busy} !== 4'b0000 ||
            a_resp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL abort_zero: ctl=%b rd=%h exp 0000 0",
                     {a_req_ready, a_resp_valid, a_resp_err, a_busy}, a_resp_rdata);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_release: v=%b rr=%b exp 0 1", a_resp_valid, a_req_ready);
        end
        do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hCAFEF00D || e !== 1'b0) begin
            errors++;
            $display("FAIL abort_nowrite: rd=%h err=%b exp cafef00d 0", rd, e);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        b_resp_ready = 1'b1;
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h40;
        b_req_wdata = 32'hA5A5A5A5; b_req_wstrb = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (b_resp_valid !== (k % 2 == 0) || b_req_ready !== (k % 2 == 1) ||
                b_resp_err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_cycle%0d: v=%b rr=%b e=%b exp %0d %0d 0",
                         k, b_resp_valid, b_req_ready, b_resp_err,
                         (k % 2 == 0), (k % 2 == 1));
            end
        end
        b_req_write = 1'b0;
        @(negedge clk);
        checks++;
        if (b_resp_valid !== 1'b1 || b_resp_rdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL b2b_load: v=%b rd=%h exp 1 a5a5a5a5",
                     b_resp_valid, b_resp_rdata);
        end
        b_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b1 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: v=%b rr=%b busy=%b exp 0 1 0",
                     b_resp_valid, b_req_ready, b_busy);
        end
        b_resp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_strobe();
        test_errors();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
